addsub_multicycle: RTL and testbench

Parametrised successor to the 8-bit add/sub flag unit. Computes WIDTH-bit a+b or a-b over WIDTH/CHUNK cycles, one CHUNK-bit slice per cycle, with a ripple carry held in a register between slices. Adds a start/busy/done handshake, registered flags, and carry-in chaining (adc/sbb) for multi-precision arithmetic. Sits between the datapath operand registers and the flag/status register of the lab CPU.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_chunk.sv | 26 ++
 rtl/addsub_multicycle.sv | 155 +++++++++++++++
 tb/tb_addsub_multicycle.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the multi-cycle add/sub unit.
package addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of chunks needed to cover the full operand width.
  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk build still needs a 1-bit index.
  function automatic int calc_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the add/sub datapath (purely combinational).
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] b_x;
  logic [CHUNK:0]   full;

  // Subtract is a + ~b + 1; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    b_x      = b ^ {CHUNK{sub}};
    full     = {1'b0, a} + {1'b0, b_x} + {{CHUNK{1'b0}}, cin};
    s        = full[CHUNK-1:0];
    cout     = full[CHUNK];
    c_msb_in = full[CHUNK-1] ^ a[CHUNK-1] ^ b_x[CHUNK-1];
  end

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle WIDTH-bit add/sub with start/busy/done handshake, registered
// flags and carry-in chaining. One CHUNK-bit slice per clock, LSB first.
module addsub_multicycle
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             use_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             ovf,
  output logic             sf,
  output logic             zf
);

  localparam int             NCH      = calc_nch(WIDTH, CHUNK);
  localparam int             IW       = calc_idx_w(NCH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NCH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             c_q, c_d;
  logic             zacc_q, zacc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cf_q, cf_d;
  logic             ovf_q, ovf_d;
  logic             sf_q, sf_d;
  logic             zf_q, zf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] ch_s;
  logic             ch_cout;
  logic             ch_c_msb_in;

  // Operands are shifted right each cycle so the active slice is always the low chunk.
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .sub      (sub_q),
    .cin      (c_q),
    .s        (ch_s),
    .cout     (ch_cout),
    .c_msb_in (ch_c_msb_in)
  );

  // Next-state, datapath and output-register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    zacc_d  = zacc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cf_d    = cf_q;
    ovf_d   = ovf_q;
    sf_d    = sf_q;
    zf_d    = zf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          // Chained op: stored cf is a carry for add, a borrow for sub.
          c_d     = use_cin ? (cf_q ^ sub) : sub;
          zacc_d  = 1'b1;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        c_d    = ch_cout;
        zacc_d = zacc_q & (ch_s == '0);
        res_d  = (res_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = res_d;
          cf_d    = ch_cout ^ sub_q;
          ovf_d   = ch_cout ^ ch_c_msb_in;
          sf_d    = ch_s[CHUNK-1];
          zf_d    = zacc_d;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      zacc_q  <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      sf_q    <= 1'b0;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      zacc_q  <= zacc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cf_q    <= cf_d;
      ovf_q   <= ovf_d;
      sf_q    <= sf_d;
      zf_q    <= zf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cf   = cf_q;
  assign ovf  = ovf_q;
  assign sf   = sf_q;
  assign zf   = zf_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Self-checking bench for addsub_multicycle: a 32/8 instance driven through a
// scoreboard and an 8/8 single-cycle instance checked directly.
module tb_addsub_multicycle;

  localparam int NCH = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cf;
    logic        ovf;
    logic        sf;
    logic        zf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub, use_cin;
  logic [31:0] a, b;
  logic        busy, done, cf, ovf, sf, zf;
  logic [31:0] sum;

  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cf8, ovf8, sf8, zf8;
  logic [7:0]  sum8;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_cf  = 1'b0;
  exp_t        sb_q[$];
  logic [31:0] got;

  always #5 clk = ~clk;

  addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .use_cin(use_cin), .busy(busy), .done(done), .sum(sum), .cf(cf),
    .ovf(ovf), .sf(sf), .zf(zf)
  );

  addsub_multicycle #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .use_cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cf(cf8),
    .ovf(ovf8), .sf(sf8), .zf(zf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the modelled result, run the op, pop and compare on done.
  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic op_sub, input logic op_cin, input logic poke,
                       output logic [31:0] res);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] bx;
    logic        c0;
    int          cyc;
    bit          seen;
    bx    = op_b ^ {32{op_sub}};
    c0    = op_cin ? (op_sub ? ~m_cf : m_cf) : op_sub;
    full  = {1'b0, op_a} + {1'b0, bx} + {32'd0, c0};
    e.sum = full[31:0];
    e.cf  = full[32] ^ op_sub;
    e.ovf = (op_a[31] == bx[31]) && (full[31] != op_a[31]);
    e.sf  = full[31];
    e.zf  = (full[31:0] == 32'd0);
    m_cf  = e.cf;
    sb_q.push_back(e);

    @(negedge clk);
    a = op_a; b = op_b; sub = op_sub; use_cin = op_cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = ~op_sub; use_cin = ~op_cin;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < NCH + 3) begin
      start = poke && (cyc == 1);
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("latency", cyc, NCH);
    e = sb_q.pop_front();
    check("sum", sum, e.sum);
    check("cf", {31'd0, cf}, {31'd0, e.cf});
    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
    check("sf", {31'd0, sf}, {31'd0, e.sf});
    check("zf", {31'd0, zf}, {31'd0, e.zf});
    check("busy_in_done", {31'd0, busy}, 32'd0);
    res = sum;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("sum_hold", sum, e.sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; use_cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;

    // Reset held while start is pulsed.
    @(negedge clk); start = 1'b1; a = 32'h1234; b = 32'h1; start8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_flags", {28'd0, cf, ovf, sf, zf}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    @(negedge clk); start = 1'b0; start8 = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

    // Single-cycle instance: 7F + 02.
    @(negedge clk); a8 = 8'h7F; b8 = 8'h02; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    check("w8_busy", {31'd0, busy8}, 32'd1);
    @(posedge clk); #1;
    check("w8_done", {31'd0, done8}, 32'd1);
    check("w8_sum", {24'd0, sum8}, 32'h81);
    check("w8_flags", {28'd0, cf8, ovf8, sf8, zf8}, 32'b0110);
    check("w8_busy_done", {31'd0, busy8}, 32'd0);
    @(posedge clk); #1;
    check("w8_done_pulse", {31'd0, done8}, 32'd0);

    // Carry across a chunk boundary, then borrow.
    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, got);
    check("lit_ff_plus_1", got, 32'h00000100);
    do_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, got);
    check("lit_borrow", got, 32'hFFFFFFFF);

    // Zero results.
    do_op(32'h00000016, 32'h00000016, 1'b1, 1'b0, 1'b0, got);
    do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, got);

    // adc / sbb chaining.
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, got);
    do_op(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, got);
    check("lit_adc", got, 32'h00000001);
    do_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, got);
    do_op(32'h00000005, 32'h00000002, 1'b1, 1'b1, 1'b0, got);
    check("lit_sbb", got, 32'h00000002);

    // Start re-asserted mid-RUN must be ignored.
    do_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, got);

    // Random mix including chained ops.
    for (int i = 0; i < 8; i++) begin
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, got);
    end

    // Async reset in the middle of an operation.
    do_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b0, got);
    @(negedge clk); a = 32'hAAAA5555; b = 32'h11111111; sub = 1'b0; use_cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sum", sum, 32'd0);
    check("midrst_flags", {27'd0, done, cf, ovf, sf, zf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    m_cf = 1'b0;
    do_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, got);
    check("lit_after_rst", got, 32'h00010000);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
